// File: rtl/alu_ex_mem_stage.sv
// EX/MEM pipeline register fed by the ALU, plus the architectural NZCV flags.
// Optional FLAG_BYPASS_EN: forwards accepted flags combinationally to flags_nzcv.
module alu_ex_mem_stage #(
  parameter int WIDTH = 64,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] store_data,
  input  logic [REGW-1:0]  dest_reg,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_store_data,
  output logic [REGW-1:0]  out_dest_reg,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic [3:0]       flags_nzcv
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] sdata;
    logic [REGW-1:0]  dest;
    logic             rw;
    logic             mr;
    logic             mw;
  } pay_t;

  pay_t       pay_q, pay_d;
  logic       valid_q, valid_d;
  logic [3:0] flags_q, flags_d;
  logic       accept;
  logic       xfer;
  logic [3:0] alu_nzcv;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign xfer     = valid_q && out_ready;
  assign alu_nzcv = {alu_n, alu_z, alu_c, alu_v};

  always_comb begin
    pay_d   = pay_q;
    valid_d = valid_q;
    flags_d = flags_q;
    if (accept) begin
      pay_d.result = alu_result;
      pay_d.sdata  = store_data;
      pay_d.dest   = dest_reg;
      pay_d.rw     = reg_write;
      pay_d.mr     = mem_read;
      pay_d.mw     = mem_write;
      valid_d      = 1'b1;
      if (set_flags) flags_d = alu_nzcv;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    // flush kills both the held and the incoming instruction
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pay_q   <= '0;
      valid_q <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      pay_q   <= pay_d;
      valid_q <= valid_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_result     = pay_q.result;
  assign out_store_data = pay_q.sdata;
  assign out_dest_reg   = pay_q.dest;
  assign out_reg_write  = valid_q && pay_q.rw;
  assign out_mem_read   = valid_q && pay_q.mr;
  assign out_mem_write  = valid_q && pay_q.mw;

`ifdef FLAG_BYPASS_EN
  // decode sees the flags of the instruction being accepted this cycle
  assign flags_nzcv = (accept && set_flags) ? alu_nzcv : flags_q;
`else
  assign flags_nzcv = flags_q;
`endif

endmodule

// File: doc/alu_ex_mem_stage.md
Name: alu_ex_mem_stage

Overview:
Execute-to-memory pipeline stage fed directly by the ALU, which is built from 4:1 mux bit slices.
- Captures the ALU result, the flag outputs and the control bundle for the instruction into a valid/ready handshaked register.
- Keeps the architectural NZCV flag register, updated by flag-setting instructions.
- The memory stage consumes the stage outputs. Decode and branch logic consume the current flags.

Parameters:
WIDTH, 64, datapath width of the ALU result and store data
REGW, 5, width of the destination register index

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU stage presents an instruction
in_ready  out  1  stage can accept this cycle
alu_result  in  WIDTH  ALU output
alu_n  in  1  negative flag from ALU
alu_z  in  1  zero flag from ALU
alu_c  in  1  carry-out from ALU
alu_v  in  1  overflow from ALU
set_flags  in  1  instruction updates NZCV
store_data  in  WIDTH  register value for STUR
dest_reg  in  REGW  write-back register index
reg_write  in  1  control: write back
mem_read  in  1  control: load
mem_write  in  1  control: store
flush  in  1  kill held and incoming instruction
out_valid  out  1  stage holds a valid instruction
out_ready  in  1  memory stage accepts
out_result  out  WIDTH  registered ALU result (memory address or write-back value)
out_store_data  out  WIDTH  registered store data
out_dest_reg  out  REGW  registered destination
out_reg_write  out  1  registered control, gated by out_valid
out_mem_read  out  1  registered control, gated by out_valid
out_mem_write  out  1  registered control, gated by out_valid
flags_nzcv  out  4  architectural flags {N,Z,C,V}

Behaviour:
Reset (async, reset_n low):
- out_valid=0, all data registers 0, control outputs 0, flags_nzcv=4'b0000.
- Reset mid-operation discards the held instruction immediately, with no clock edge needed.

Handshake:
- in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
- accept = in_valid && in_ready && !flush.
- Output transfer occurs when out_valid && out_ready.

Register update (posedge clk):
- If accept: load all payload registers; out_valid<=1. Latency is 1 cycle from accept to out_valid.
- Else if transfer: out_valid<=0. Payload is held; its value does not matter.
- Else: hold everything. out_valid stays 1 and payload is stable while out_ready=0. This is a stall.
- flush=1: out_valid<=0 regardless of accept or transfer. The incoming instruction is dropped, and in_ready is still driven per formula.

Control gating:
- out_reg_write, out_mem_read and out_mem_write are 0 whenever out_valid=0.

Flags:
- On accept with set_flags=1: flags_nzcv<={alu_n,alu_z,alu_c,alu_v} at the same edge as the payload load.
- Instructions with set_flags=0 leave the flags unchanged.
- A flushed instruction never updates the flags.
- A stalled held instruction does not re-update the flags.
- Back-to-back accepts with set_flags: the last accepted instruction wins.

Widths:
- No arithmetic is performed; all fields pass through at their declared widths.
- mem_read and mem_write both 1 is illegal upstream. It is passed through unchanged, with no checking.

Optional Feature:
FLAG_BYPASS_EN
- Defined: flags_nzcv is combinational. It equals {alu_n,alu_z,alu_c,alu_v} when (in_valid && in_ready && !flush && set_flags), otherwise the flag register. A conditional branch in decode sees the flags of the instruction currently in EX without a bubble. The register update is unchanged.
- Undefined: flags_nzcv is the flag register output only, giving a one-cycle visibility delay.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> out_valid=0, out_result=0, flags_nzcv=0000. Release, then apply in_valid=1, alu_result=64'h10, out_ready=1 -> next cycle out_valid=1, out_result=64'h10.
- Stall: accept result 64'hA, then out_ready=0 for 3 cycles with new in_valid result 64'hB -> in_ready=0, out_result stays 64'hA. Raise out_ready -> 64'hB appears the following cycle.
- Flags: accept set_flags=1 with N=1,Z=0,C=1,V=0 -> flags_nzcv=1010. Then accept set_flags=0 with flags 0101 -> flags remain 1010.
- Flush: while holding a valid instruction, assert flush with in_valid=1, set_flags=1, flags 0100 -> out_valid=0 next cycle, flags_nzcv unchanged, out_mem_write=0.
- Async reset mid-stream: drop reset_n between clock edges while out_valid=1 -> out_valid and flags clear immediately, before the next edge.
- FLAG_BYPASS_EN: present set_flags=1 with Z=1 (0100) and an accepting handshake -> flags_nzcv=0100 in the same cycle. Without the macro, 0100 appears only after the clock edge.
